// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared access-size, FSM and pending-bundle types for the MEM/WB stage
package mem_wb_stage_pkg;

  localparam logic [1:0] SIZE_WORD = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_BYTE = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] pc;
    logic [4:0]  addr;
    logic        we;
    logic        is_load;
    logic [1:0]  size;
    logic [1:0]  off;
  } pend_t;

  // Size 3 is not a legal encoding and is handled as a word access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = off[0];
      default:   misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian byte-lane steering for stores and sign-extending load extract
module mem_lane_align
  import mem_wb_stage_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  assign o_misaligned = misaligned(i_st_size, i_st_off);

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_st_data;
    case (i_st_size)
      SIZE_HALF: begin
        o_be    = i_st_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_st_data[15:0]}};
      end
      SIZE_BYTE: begin
        o_be    = 4'b0001 << i_st_off;
        o_wdata = {4{i_st_data[7:0]}};
      end
      default: ;
    endcase
  end

  assign w_ld_byte = i_rdata[{i_ld_off, 3'b000} +: 8];
  assign w_ld_half = i_rdata[{i_ld_off[1], 4'b0000} +: 16];

  always_comb begin
    o_ld_data = i_rdata;
    case (i_ld_size)
      SIZE_HALF: o_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      SIZE_BYTE: o_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      default:   ;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MIPS memory-access stage with req/ack data bus and MEM/WB register
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCNext_in,
  input  logic [31:0] ReadData2_in,
  input  logic [1:0]  state_of_type_in,
  input  logic        data_mem_en_in,
  input  logic [31:0] ALU_result_in,
  input  logic        wb_data_sel_in,
  input  logic        wb_addr_sel_in,
  input  logic        wb_write_en_in,
  input  logic [4:0]  wb_addr1_in,
  input  logic [4:0]  wb_addr2_in,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] wb_data_out,
  output logic [4:0]  wb_addr_out,
  output logic        wb_write_en_out,
  output logic [31:0] PCNext_out,
  output logic        align_err_out
);

  state_e      r_state;
  pend_t       r_pend;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_addr;
  logic        r_wb_we;
  logic [31:0] r_pc;
  logic        r_align_err;

  logic        w_mem_op;
  logic        w_is_load;
  logic        w_misaligned;
  logic        w_launch;
  logic        w_bad_op;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_data;
  logic [4:0]  w_wb_addr;

  // A store wins when both the store and load controls are set.
  assign w_mem_op  = data_mem_en_in | wb_data_sel_in;
  assign w_is_load = wb_data_sel_in & ~data_mem_en_in;
  assign w_launch  = w_mem_op & ~w_misaligned;
  assign w_bad_op  = w_mem_op & w_misaligned;
  assign w_wb_addr = wb_addr_sel_in ? wb_addr2_in : wb_addr1_in;

  assign stall_out = (r_state == ST_IDLE) ? w_launch : ~mem_ack;

  mem_lane_align u_lane (
    .i_st_size    (state_of_type_in),
    .i_st_off     (ALU_result_in[1:0]),
    .i_st_data    (ReadData2_in),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned),
    .i_ld_size    (r_pend.size),
    .i_ld_off     (r_pend.off),
    .i_rdata      (mem_rdata),
    .o_ld_data    (w_ld_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_pend      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_wb_data   <= '0;
      r_wb_addr   <= '0;
      r_wb_we     <= 1'b0;
      r_pc        <= '0;
      r_align_err <= 1'b0;
    end else begin
      r_align_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_mem_req    <= 1'b1;
            r_mem_we     <= data_mem_en_in;
            r_mem_addr   <= {ALU_result_in[31:2], 2'b00};
            r_mem_be     <= w_be;
            r_mem_wdata  <= w_wdata;
            r_pend.alu     <= ALU_result_in;
            r_pend.pc      <= PCNext_in;
            r_pend.addr    <= w_wb_addr;
            r_pend.we      <= wb_write_en_in;
            r_pend.is_load <= w_is_load;
            r_pend.size    <= state_of_type_in;
            r_pend.off     <= ALU_result_in[1:0];
            r_wb_we      <= 1'b0;
            r_state      <= ST_BUSY;
          end else begin
            // Misaligned accesses retire as a bubble with a one-cycle error flag.
            r_wb_data   <= ALU_result_in;
            r_wb_addr   <= w_wb_addr;
            r_wb_we     <= wb_write_en_in & ~w_bad_op;
            r_pc        <= PCNext_in;
            r_align_err <= w_bad_op;
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_wb_data <= r_pend.is_load ? w_ld_data : r_pend.alu;
            r_wb_addr <= r_pend.addr;
            r_wb_we   <= r_pend.we;
            r_pc      <= r_pend.pc;
            r_state   <= ST_IDLE;
          end else begin
            r_wb_we <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req         = r_mem_req;
  assign mem_we          = r_mem_we;
  assign mem_addr        = r_mem_addr;
  assign mem_be          = r_mem_be;
  assign mem_wdata       = r_mem_wdata;
  assign wb_data_out     = r_wb_data;
  assign wb_addr_out     = r_wb_addr;
  assign wb_write_en_out = r_wb_we;
  assign PCNext_out      = r_pc;
  assign align_err_out   = r_align_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCNext_in, ReadData2_in, ALU_result_in, mem_rdata;
  logic [1:0]  state_of_type_in;
  logic        data_mem_en_in, wb_data_sel_in, wb_addr_sel_in, wb_write_en_in, mem_ack;
  logic [4:0]  wb_addr1_in, wb_addr2_in;
  logic        stall_out, mem_req, mem_we, wb_write_en_out, align_err_out;
  logic [31:0] mem_addr, mem_wdata, wb_data_out, PCNext_out;
  logic [3:0]  mem_be;
  logic [4:0]  wb_addr_out;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] pc;
  } wb_t;

  wb_t sb_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk              (clk),
    .reset            (reset),
    .PCNext_in        (PCNext_in),
    .ReadData2_in     (ReadData2_in),
    .state_of_type_in (state_of_type_in),
    .data_mem_en_in   (data_mem_en_in),
    .ALU_result_in    (ALU_result_in),
    .wb_data_sel_in   (wb_data_sel_in),
    .wb_addr_sel_in   (wb_addr_sel_in),
    .wb_write_en_in   (wb_write_en_in),
    .wb_addr1_in      (wb_addr1_in),
    .wb_addr2_in      (wb_addr2_in),
    .stall_out        (stall_out),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_be           (mem_be),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_ack          (mem_ack),
    .wb_data_out      (wb_data_out),
    .wb_addr_out      (wb_addr_out),
    .wb_write_en_out  (wb_write_en_out),
    .PCNext_out       (PCNext_out),
    .align_err_out    (align_err_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    PCNext_in = '0; ReadData2_in = '0; ALU_result_in = '0; state_of_type_in = '0;
    data_mem_en_in = 0; wb_data_sel_in = 0; wb_addr_sel_in = 0; wb_write_en_in = 0;
    wb_addr1_in = '0; wb_addr2_in = '0;
  endtask

  task automatic present(input logic st, input logic ld, input logic [1:0] size,
                         input logic [31:0] alu, input logic [31:0] sdata, input logic sel,
                         input logic [4:0] a1, input logic [4:0] a2, input logic we,
                         input logic [31:0] pc);
    data_mem_en_in = st; wb_data_sel_in = ld; state_of_type_in = size;
    ALU_result_in = alu; ReadData2_in = sdata; wb_addr_sel_in = sel;
    wb_addr1_in = a1; wb_addr2_in = a2; wb_write_en_in = we; PCNext_in = pc;
  endtask

  task automatic check_wb(input string tag);
    wb_t e;
    if (sb_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".wb_data"}, wb_data_out, e.data);
      chk({tag, ".wb_addr"}, {27'd0, wb_addr_out}, {27'd0, e.addr});
      chk({tag, ".wb_we"}, {31'd0, wb_write_en_out}, {31'd0, e.we});
      chk({tag, ".pc"}, PCNext_out, e.pc);
    end
  endtask

  // Aligned memory op: the bench acts as the bus slave, acking after `waits` BUSY cycles.
  task automatic do_mem(input string tag, input logic st, input logic [1:0] size,
                        input logic [31:0] alu, input logic [31:0] sdata, input logic [31:0] rdata,
                        input int waits, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_wb, input logic [4:0] a1, input logic we,
                        input logic [31:0] pc);
    int stalls = 0;
    present(st, ~st, size, alu, sdata, 1'b0, a1, 5'd0, we, pc);
    sb_q.push_back('{exp_wb, a1, we, pc});
    @(negedge clk);
    if (stall_out) stalls++;
    chk({tag, ".req_pre"}, {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    chk({tag, ".req"}, {31'd0, mem_req}, 32'd1);
    chk({tag, ".addr"}, mem_addr, {alu[31:2], 2'b00});
    chk({tag, ".be"}, {28'd0, mem_be}, {28'd0, exp_be});
    chk({tag, ".we"}, {31'd0, mem_we}, {31'd0, st});
    if (st) chk({tag, ".wdata"}, mem_wdata, exp_wdata);
    repeat (waits) begin
      @(negedge clk);
      if (stall_out) stalls++;
      mem_rdata = $urandom;
      @(posedge clk); #1;
      chk({tag, ".bubble"}, {31'd0, wb_write_en_out}, 32'd0);
      chk({tag, ".addr_hold"}, mem_addr, {alu[31:2], 2'b00});
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = rdata;
    #1;
    chk({tag, ".stall_ack"}, {31'd0, stall_out}, 32'd0);
    chk({tag, ".stall_cycles"}, stalls, waits + 1);
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = $urandom;
    clear_inputs();
    chk({tag, ".req_done"}, {31'd0, mem_req}, 32'd0);
    check_wb(tag);
  endtask

  initial begin
    clear_inputs();
    mem_ack = 1'b0; mem_rdata = '0;
    reset = 1'b0;
    @(negedge clk);
    chk("rst.mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_be_we", {27'd0, mem_be, mem_we}, 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.wb_data", wb_data_out, 32'd0);
    chk("rst.wb_misc", {25'd0, wb_addr_out, wb_write_en_out, align_err_out}, 32'd0);
    chk("rst.pc", PCNext_out, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Non-memory op retires in one cycle
    present(1'b0, 1'b0, SIZE_WORD, 32'h0000_1234, 32'h0, 1'b1, 5'd3, 5'd7, 1'b1, 32'h0000_0404);
    sb_q.push_back('{32'h0000_1234, 5'd7, 1'b1, 32'h0000_0404});
    @(negedge clk);
    chk("alu.stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    chk("alu.no_req", {31'd0, mem_req}, 32'd0);
    check_wb("alu");

    do_mem("lw",  1'b0, SIZE_WORD, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3, 4'b1111, 32'h0,
           32'hDEAD_BEEF, 5'd5, 1'b1, 32'h0000_0408);
    do_mem("sb",  1'b1, SIZE_BYTE, 32'h0000_0203, 32'h0000_00A5, 32'h0, 0, 4'b1000, 32'hA5A5_A5A5,
           32'h0000_0203, 5'd0, 1'b0, 32'h0000_040C);
    do_mem("lh",  1'b0, SIZE_HALF, 32'h0000_0042, 32'h0, 32'h8001_0000, 1, 4'b1100, 32'h0,
           32'hFFFF_8001, 5'd9, 1'b1, 32'h0000_0410);
    do_mem("lb",  1'b0, SIZE_BYTE, 32'h0000_0301, 32'h0, 32'h0000_7F00, 0, 4'b0010, 32'h0,
           32'h0000_007F, 5'd10, 1'b1, 32'h0000_0414);
    do_mem("sh",  1'b1, SIZE_HALF, 32'h0000_0002, 32'h1234_BEEF, 32'h0, 2, 4'b1100, 32'hBEEF_BEEF,
           32'h0000_0002, 5'd0, 1'b0, 32'h0000_0418);
    do_mem("sw3", 1'b1, 2'd3, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 1, 4'b1111, 32'hCAFE_F00D,
           32'h0000_0010, 5'd0, 1'b0, 32'h0000_041C);
    do_mem("lbn", 1'b0, SIZE_BYTE, 32'h0000_0503, 32'h0, 32'h9A00_0000, 0, 4'b1000, 32'h0,
           32'hFFFF_FF9A, 5'd11, 1'b1, 32'h0000_0420);

    // Misaligned word load: no bus access, one-cycle error, no write
    present(1'b0, 1'b1, SIZE_WORD, 32'h0000_0102, 32'h0, 1'b0, 5'd4, 5'd0, 1'b1, 32'h0000_0424);
    @(negedge clk);
    chk("mis.stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    chk("mis.err", {31'd0, align_err_out}, 32'd1);
    chk("mis.wb_we", {31'd0, wb_write_en_out}, 32'd0);
    chk("mis.req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    chk("mis.err_pulse", {31'd0, align_err_out}, 32'd0);
    chk("mis.req2", {31'd0, mem_req}, 32'd0);

    // Reset while BUSY, then a stale ack after release
    present(1'b0, 1'b1, SIZE_WORD, 32'h0000_0400, 32'h0, 1'b0, 5'd6, 5'd0, 1'b1, 32'h0000_0428);
    @(posedge clk); #1;
    chk("rb.req", {31'd0, mem_req}, 32'd1);
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rb.req_async", {31'd0, mem_req}, 32'd0);
    chk("rb.stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    chk("rb.stall_ack", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("rb.no_wb", {31'd0, wb_write_en_out}, 32'd0);
    chk("rb.wb_data", wb_data_out, 32'd0);
    chk("rb.req_after", {31'd0, mem_req}, 32'd0);

    // Back in IDLE: a plain ALU op retires in one cycle
    present(1'b0, 1'b0, SIZE_WORD, 32'h0000_00AB, 32'h0, 1'b0, 5'd12, 5'd0, 1'b1, 32'h0000_042C);
    sb_q.push_back('{32'h0000_00AB, 5'd12, 1'b1, 32'h0000_042C});
    @(posedge clk); #1;
    clear_inputs();
    check_wb("post_rst");
    chk("sb.drained", sb_q.size(), 32'd0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

- Memory-access stage of the 5-stage MIPS pipeline, fed directly by the EX/MEM register outputs.
- Performs data-memory loads and stores over a req/ack bus, with byte-lane steering and load sign extension.
- Stalls upstream while a transfer is outstanding, then registers the writeback bundle (MEM/WB) for the register file.

## Interface
- No parameters. Data width 32, register address width 5, fixed.
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- PCNext_in  in  32  link address, passed to WB
- ReadData2_in  in  32  store data
- state_of_type_in  in  2  access size: 0 word, 1 half, 2 byte, 3 treated as word
- data_mem_en_in  in  1  store request
- ALU_result_in  in  32  memory byte address / ALU result
- wb_data_sel_in  in  1  1 = load (write back memory data), 0 = write back ALU result
- wb_addr_sel_in  in  1  0 selects wb_addr1_in, 1 selects wb_addr2_in
- wb_write_en_in  in  1  register-file write enable
- wb_addr1_in, wb_addr2_in  in  5  candidate destination registers
- stall_out  out  1  combinational; upstream holds EX/MEM while high
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  1 = store
- mem_addr  out  32  word-aligned address ({ALU_result[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  load data, valid with mem_ack
- mem_ack  in  1  single-cycle completion pulse
- wb_data_out  out  32  writeback data
- wb_addr_out  out  5  writeback register
- wb_write_en_out  out  1  writeback enable
- PCNext_out  out  32  registered PCNext
- align_err_out  out  1  one-cycle pulse on misaligned access

## Operation
- Memory op: data_mem_en_in=1 (store) or wb_data_sel_in=1 (load). Store takes priority if both are set.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠0.
  - No bus access.
  - Next cycle: align_err_out=1, wb_write_en_out=0.
- FSM with two states:
  - IDLE
    - Non-memory op: register the writeback bundle at the next edge; stall_out=0.
    - Aligned memory op: stall_out=1. At the edge, latch addr/be/wdata/we/size/byte offset and the WB fields, set mem_req=1, go to BUSY.
  - BUSY
    - stall_out = ~mem_ack.
    - On mem_ack, at the edge: write the MEM/WB outputs, clear mem_req, go to IDLE.
    - mem_ack sampled in IDLE is ignored.
- Store lanes (little-endian):
  - Word: be=1111, wdata=data.
  - Half: be = addr[1] ? 1100 : 0011, wdata={2{data[15:0]}}.
  - Byte: be=0001<<addr[1:0], wdata={4{data[7:0]}}.
  - Loads drive be per size, we=0.
- Load extract:
  - Byte = rdata[8*off+7:8*off].
  - Half = rdata[16*addr[1]+15:16*addr[1]].
  - Result is sign-extended to 32 bits.
- Writeback outputs:
  - wb_data_out = load ? extracted : ALU_result.
  - wb_addr_out = wb_addr_sel ? addr2 : addr1.
  - wb_write_en_out and PCNext_out pass through.
- Bubble rule: every edge at which stall_out=1 loads wb_write_en_out=0; the other WB outputs hold.

## Timing
- Reset: state IDLE. All outputs except stall_out are 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_data_out, wb_addr_out, wb_write_en_out, PCNext_out, align_err_out.
- Latency:
  - Non-memory op: 1 cycle.
  - Memory op: 1 launch cycle, plus cycles until ack, plus the ack edge. With ack on the first BUSY cycle, the result appears 2 cycles after presentation.
- stall_out falls in the ack cycle, so EX/MEM advances on the same edge the result is registered. The next instruction is evaluated in IDLE on the following cycle.
- mem_addr, be, wdata and we are stable from the req rise through the ack cycle.
- Reset asserted mid-BUSY: immediate return to IDLE, mem_req=0. A late ack is ignored.

## Structure
- Shared pipeline package: access-size encodings (SIZE_WORD=0, SIZE_HALF=1, SIZE_BYTE=2) and FSM state encoding.
- One natural sub-module, mem_lane_align (combinational):
  - Store side: be/wdata generation and misalignment detect.
  - Load side: extract and sign-extend.

## Test plan
- Non-memory op: ALU_result=0x1234, wb_addr_sel=1, addr2=7, we=1 -> next cycle wb_data_out=0x1234, wb_addr_out=7, wb_write_en_out=1, no mem_req.
- lw at addr 0x100, ack after 3 BUSY cycles with rdata=0xDEADBEEF:
  - mem_addr=0x100, be=1111.
  - stall_out high for 4 cycles.
  - wb_write_en_out=0 during the stall.
  - wb_data_out=0xDEADBEEF after the ack edge.
- sb data=0x000000A5 at addr 0x203 -> mem_addr=0x200, be=1000, wdata=0xA5A5A5A5, we=1.
- lh at addr 0x42, rdata=0x8001_0000 -> wb_data_out=0xFFFF8001. lb at offset 1 of 0x00007F00 -> 0x0000007F.
- lw at 0x102 -> no mem_req, align_err_out pulse 1 cycle, wb_write_en_out=0, stall_out=0.
- Reset asserted in BUSY, then ack pulsed after release -> mem_req=0, state IDLE, no writeback, stall_out=0.
